cla_seq_addsub: RTL
===================

# cla_seq_addsub

Sequencing controller that performs multi-word add/subtract on wide operands by time-sharing a single 16-bit carry-lookahead adder slice (the team's CLA16bit). It latches two WORDS×16-bit operands on a start handshake. It then feeds one 16-bit slice per cycle to the CLA, LSB slice first, chaining the carry through a register, and pulses done with sum, carry-out, signed-overflow and zero flags. It sits between the ALU issue logic and the CLA datapath.

## Interface
- WORDS, default 4: number of 16-bit slices; operand width W = 16*WORDS; legal range 2..16.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  request a new operation; sampled only in IDLE.
- sub  input  1  0 = add, 1 = subtract; latched with the operands at start.
- cin  input  1  carry-in for add; ignored when sub=1.
- a  input  W  operand A; latched at start.
- b  input  W  operand B; latched at start.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse; result and flags valid.
- s  output  W  result register.
- cout  output  1  final carry-out of MSB slice; for sub, 1 = no borrow.
- ovf  output  1  two's-complement signed overflow.
- zero  output  1  s == 0.

## Operation
- Reset values: state IDLE, busy 0, done 0, s 0, cout 0, ovf 0, zero 0, slice counter 0, carry register 0.
- States: IDLE, RUN, DONE.
  - IDLE: start=1 latches a, b, sub; sets carry register = (sub ? 1 : cin); sets counter 0; goes to RUN. start=0 stays in IDLE.
  - RUN: the CLA input a is a_q[16k+:16]. The CLA input b is b_q[16k+:16], or its bitwise inverse when sub_q=1. The CLA cin is the carry register.
    - Each edge: s[16k+:16] ← CLA s; carry register ← CLA cout; k ← k+1.
    - On the edge where k = WORDS-1: go to DONE. cout ← CLA cout. ovf ← (a_q[W-1] == b'[W-1]) && (sum MSB != a_q[W-1]), where b' is the post-inversion B. zero ← (full assembled s == 0). done ← 1.
  - DONE: done=1 for exactly this cycle; next edge → IDLE, done ← 0. start is ignored in DONE.
- start is ignored in RUN and DONE. No queueing; the ignored request is lost.
- s, cout, ovf and zero hold their values from DONE until the next accepted start. The upper slices of s retain stale data during RUN and are valid only while done=1 or afterwards in IDLE.
- Arithmetic:
  - add: s = a + b + cin mod 2^W.
  - sub: s = a + ~b + 1 = a − b mod 2^W.
  - Unsigned carry/borrow comes only from cout. Signed overflow comes only from ovf.
- Reset mid-operation (any state) forces all outputs and internal registers to their reset values on that edge. done never pulses for the aborted operation.
- Counter width is clog2(WORDS); the counter never wraps past WORDS-1.

## Timing
- Edge E0: start sampled high in IDLE. busy=1 after E0.
- Edges E1..E(WORDS): slices 0..WORDS-1 written, one per edge. The carry ripples through the register with a latency of 1 cycle per slice.
- done=1 and flags valid between E(WORDS) and E(WORDS+1).
- busy=0 after E(WORDS+1). The earliest next accepted start is at E(WORDS+2).
- Throughput with start held high: one operation per WORDS+2 cycles (6 for WORDS=4).
- The CLA path is combinational within one cycle. There is no output back-pressure, and done is not held.

## Test plan
- WORDS=4, a=3000, b=2000, sub=0, cin=1 → done at E5; s=5001, cout=0, ovf=0, zero=0; busy high from after E0 to after E5.
- a=0xFFFF_FFFF_FFFF_FFFF, b=1, cin=0, add → s=0, cout=1, zero=1, ovf=0. The carry propagates through all 4 slices.
- sub=1, a=5, b=7 → s=0xFFFF_FFFF_FFFF_FFFE, cout=0 (borrow), ovf=0, zero=0. Repeat with a=7, b=5 → s=2, cout=1.
- a=0x7FFF_FFFF_FFFF_FFFF, b=1, add → s=0x8000_0000_0000_0000, ovf=1, cout=0. Also sub with a=0x8000_0000_0000_0000, b=1 → s=0x7FFF_FFFF_FFFF_FFFF, ovf=1.
- Start A (3000+2000) at E0, then start with new operands at E2 → ignored; done at E5 with s=5000+cin of A. Separately, assert rst at E2 of an operation → after E2 busy=0, s=0, all flags 0, no done pulse.
- start held high for 20 cycles with fixed operands → done pulses at E5, E11, E17; every result is identical and correct.

Source files
------------

// File: rtl/cla_seq_addsub.sv
// Multi-word add/sub that time-shares one 16-bit carry-lookahead slice, LSB slice first.
// Latency WORDS+1 cycles from accepted start to done; no back-pressure, start is dropped while busy.
module cla_seq_addsub #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sub,
  input  logic                  cin,
  input  logic [16*WORDS-1:0]   a,
  input  logic [16*WORDS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [16*WORDS-1:0]   s,
  output logic                  cout,
  output logic                  ovf,
  output logic                  zero
);
  localparam int W  = 16 * WORDS;
  localparam int CW = $clog2(WORDS);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, s_q, s_d;
  logic            sub_q, sub_d, carry_q, carry_d;
  logic [CW-1:0]   k_q, k_d;
  logic            cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;

  logic [15:0]     op_a, op_b, cla_s, g, p;
  logic [16:0]     c;
  logic [3:0]      gg, pg;
  logic [4:0]      cg;
  logic            cla_co;

  // 16-bit CLA: 4-bit groups with group generate/propagate, carry-in from the chain register
  always_comb begin
    op_a = a_q[16*int'(k_q) +: 16];
    op_b = sub_q ? ~b_q[16*int'(k_q) +: 16] : b_q[16*int'(k_q) +: 16];
    g    = op_a & op_b;
    p    = op_a ^ op_b;
    c    = '0;
    cg   = '0;
    cg[0] = carry_q;
    for (int j = 0; j < 4; j++) begin
      gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      pg[j] = &p[4*j +: 4];
      cg[j+1] = gg[j] | (pg[j] & cg[j]);
    end
    for (int j = 0; j < 4; j++) begin
      c[4*j]   = cg[j];
      c[4*j+1] = g[4*j] | (p[4*j] & cg[j]);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & cg[j]);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & cg[j]);
    end
    c[16]  = cg[4];
    cla_s  = p ^ c[15:0];
    cla_co = c[16];
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    sub_d   = sub_q;
    carry_d = carry_q;
    k_d     = k_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sub_d   = sub;
          carry_d = sub ? 1'b1 : cin;
          k_d     = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        s_d[16*int'(k_q) +: 16] = cla_s;
        carry_d = cla_co;
        if (k_q == CW'(WORDS-1)) begin
          state_d = ST_DONE;
          cout_d  = cla_co;
          ovf_d   = (a_q[W-1] == op_b[15]) && (cla_s[15] != a_q[W-1]);
          zero_d  = (s_d == '0);
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      k_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      k_q     <= k_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);
  assign s    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;
endmodule
